// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - load-use stall, branch flush and operand forwarding control
module pipeline_hazard_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ifid_rs1,
   input  logic [4:0]  ifid_rs2,
   input  logic [4:0]  idex_rs1,
   input  logic [4:0]  idex_rs2,
   input  logic [4:0]  idex_rd,
   input  logic        idex_memread,
   input  logic        idex_regwrite,
   input  logic [4:0]  exmem_rd,
   input  logic        exmem_regwrite,
   input  logic [4:0]  memwb_rd,
   input  logic        memwb_regwrite,
   input  logic        branch_taken,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        idex_bubble,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exmem_flush,
   output logic [1:0]  forward_a,
   output logic [1:0]  forward_b,
   output logic [1:0]  state,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      STALL = 2'b01,
      FLUSH = 2'b10
   } state_t;

   state_t cur_state;
   state_t nxt_state;
   logic   load_use;
   logic   stall_evt;
   logic   flush_evt;

   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] ex_rd,
      input logic       ex_we,
      input logic [4:0] wb_rd,
      input logic       wb_we
   );
      if (ex_we && (ex_rd != 5'd0) && (ex_rd == rs))
         return 2'b10;
      else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   always_comb begin
      load_use = idex_memread && idex_regwrite && (idex_rd != 5'd0) &&
                 ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
   end

   always_comb begin
      forward_a = 2'b00;
      forward_b = 2'b00;
      if (!reset) begin
         forward_a = fwd_sel(idex_rs1, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
         forward_b = fwd_sel(idex_rs2, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
      end
   end

   // A taken branch outranks a load-use stall; FLUSH ignores both since its slots are squashed.
   always_comb begin
      nxt_state   = cur_state;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      stall_evt   = 1'b0;
      flush_evt   = 1'b0;
      if (reset) begin
         nxt_state   = RUN;
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else begin
         case (cur_state)
            RUN: begin
               if (branch_taken) begin
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  flush_evt   = 1'b1;
                  nxt_state   = FLUSH;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
                  stall_evt   = 1'b1;
                  nxt_state   = STALL;
               end else begin
                  nxt_state   = RUN;
               end
            end
            STALL: begin
               if (branch_taken) begin
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  flush_evt   = 1'b1;
                  nxt_state   = FLUSH;
               end else begin
                  nxt_state   = RUN;
               end
            end
            FLUSH:   nxt_state = RUN;
            default: nxt_state = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state   <= RUN;
         stall_count <= 16'd0;
         flush_count <= 16'd0;
      end else begin
         cur_state <= nxt_state;
         if (stall_evt && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
         if (flush_evt && (flush_count != 16'hFFFF))
            flush_count <= flush_count + 16'd1;
      end
   end

   assign state = cur_state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed and randomized checks against a behavioural model
module tb_pipeline_hazard_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
   logic        idex_memread, idex_regwrite, exmem_regwrite, memwb_regwrite, branch_taken;
   logic        pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush;
   logic [1:0]  forward_a, forward_b, state;
   logic [15:0] stall_count, flush_count;

   int passed = 0;
   int total  = 0;
   bit chk_on = 1'b0;

   // model: mode 0 = running, 1 = stall slot, 2 = flush slot
   int m_mode = 0;
   int m_stalls = 0;
   int m_flushes = 0;

   always #5 clk = ~clk;

   pipeline_hazard_controller dut (
      .clk(clk), .reset(reset),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
      .idex_rd(idex_rd), .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
      .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
      .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
      .branch_taken(branch_taken),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .forward_a(forward_a), .forward_b(forward_b), .state(state),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit m_lu();
      return idex_memread && idex_regwrite && idex_rd != 0 &&
             (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
   endfunction

   function automatic int m_fwd(input logic [4:0] rs);
      if (reset) return 0;
      if (exmem_regwrite && exmem_rd != 0 && exmem_rd == rs) return 2;
      if (memwb_regwrite && memwb_rd != 0 && memwb_rd == rs) return 1;
      return 0;
   endfunction

   function automatic bit m_branch_now();
      return branch_taken && m_mode != 2;
   endfunction

   function automatic bit m_stall_now();
      return m_mode == 0 && !branch_taken && m_lu();
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_mode = 0; m_stalls = 0; m_flushes = 0;
      end else if (m_branch_now()) begin
         m_mode = 2;
         if (m_flushes < 65535) m_flushes++;
      end else if (m_stall_now()) begin
         m_mode = 1;
         if (m_stalls < 65535) m_stalls++;
      end else begin
         m_mode = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         bit st, br;
         st = !reset && m_stall_now();
         br = !reset && m_branch_now();
         chk("pc_write",    32'(pc_write),    reset ? 0 : 32'(!st));
         chk("ifid_write",  32'(ifid_write),  reset ? 0 : 32'(!st));
         chk("idex_bubble", 32'(idex_bubble), reset ? 1 : 32'(st));
         chk("ifid_flush",  32'(ifid_flush),  reset ? 1 : 32'(br));
         chk("idex_flush",  32'(idex_flush),  reset ? 1 : 32'(br));
         chk("exmem_flush", 32'(exmem_flush), reset ? 1 : 32'(br));
         chk("forward_a",   32'(forward_a),   32'(m_fwd(idex_rs1)));
         chk("forward_b",   32'(forward_b),   32'(m_fwd(idex_rs2)));
         chk("state",       32'(state),       32'(m_mode));
         chk("stall_count", 32'(stall_count), 32'(m_stalls));
         chk("flush_count", 32'(flush_count), 32'(m_flushes));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      ifid_rs1 = 0; ifid_rs2 = 0; idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0;
      exmem_rd = 0; memwb_rd = 0; idex_memread = 0; idex_regwrite = 0;
      exmem_regwrite = 0; memwb_regwrite = 0; branch_taken = 0;
   endtask

   initial begin
      reset = 1'b1;
      clr();
      cyc();
      cyc();
      chk_on = 1'b1;
      // reset outputs, with a forwarding match present that must be masked
      exmem_rd = 3; exmem_regwrite = 1; idex_rs1 = 3;
      #1;
      chk("rst state", 32'(state), 0);
      chk("rst stall_count", 32'(stall_count), 0);
      chk("rst pc_write", 32'(pc_write), 0);
      chk("rst bubble", 32'(idex_bubble), 1);
      chk("rst exmem_flush", 32'(exmem_flush), 1);
      chk("rst forward_a", 32'(forward_a), 0);
      reset = 1'b0;
      clr();
      #1;
      chk("post-rst pc_write", 32'(pc_write), 1);

      // load-use stall
      idex_memread = 1; idex_regwrite = 1; idex_rd = 5; ifid_rs2 = 5;
      #1;
      chk("lu pc_write", 32'(pc_write), 0);
      chk("lu ifid_write", 32'(ifid_write), 0);
      chk("lu bubble", 32'(idex_bubble), 1);
      cyc();
      chk("stall state", 32'(state), 1);
      chk("stall count", 32'(stall_count), 1);
      chk("stall pc_write", 32'(pc_write), 1);
      chk("stall bubble", 32'(idex_bubble), 0);
      clr();
      cyc();
      chk("after stall state", 32'(state), 0);

      // branch in RUN
      branch_taken = 1;
      #1;
      chk("br ifid_flush", 32'(ifid_flush), 1);
      chk("br idex_flush", 32'(idex_flush), 1);
      chk("br exmem_flush", 32'(exmem_flush), 1);
      chk("br pc_write", 32'(pc_write), 1);
      cyc();
      chk("flush state", 32'(state), 2);
      chk("flush count", 32'(flush_count), 1);
      chk("flush ignores branch", 32'(ifid_flush), 0);
      branch_taken = 0;
      cyc();
      chk("after flush state", 32'(state), 0);

      // branch together with load-use
      branch_taken = 1; idex_memread = 1; idex_regwrite = 1; idex_rd = 7; ifid_rs1 = 7;
      #1;
      chk("br+lu flush", 32'(idex_flush), 1);
      chk("br+lu bubble", 32'(idex_bubble), 0);
      cyc();
      chk("br+lu stall_count", 32'(stall_count), 1);
      chk("br+lu flush_count", 32'(flush_count), 2);
      clr();
      cyc();

      // forwarding priority
      exmem_rd = 3; memwb_rd = 3; exmem_regwrite = 1; memwb_regwrite = 1; idex_rs1 = 3;
      #1;
      chk("fwd exmem", 32'(forward_a), 2);
      exmem_regwrite = 0;
      #1;
      chk("fwd memwb", 32'(forward_a), 1);
      idex_rs1 = 0;
      #1;
      chk("fwd none", 32'(forward_a), 0);
      idex_rs2 = 3;
      #1;
      chk("fwd_b memwb", 32'(forward_b), 1);
      clr();

      // reset during STALL
      idex_memread = 1; idex_regwrite = 1; idex_rd = 9; ifid_rs1 = 9;
      cyc();
      chk("pre-rst stall state", 32'(state), 1);
      reset = 1;
      clr();
      cyc();
      chk("rst-in-stall state", 32'(state), 0);
      chk("rst-in-stall stall_count", 32'(stall_count), 0);
      chk("rst-in-stall flush_count", 32'(flush_count), 0);
      reset = 0;

      // randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(63) == 0);
         ifid_rs1       = 5'($urandom_range(3));
         ifid_rs2       = 5'($urandom_range(3));
         idex_rs1       = 5'($urandom_range(3));
         idex_rs2       = 5'($urandom_range(3));
         idex_rd        = 5'($urandom_range(3));
         exmem_rd       = 5'($urandom_range(3));
         memwb_rd       = 5'($urandom_range(3));
         idex_memread   = 1'($urandom_range(1));
         idex_regwrite  = 1'($urandom_range(1));
         exmem_regwrite = 1'($urandom_range(1));
         memwb_regwrite = 1'($urandom_range(1));
         branch_taken   = ($urandom_range(5) == 0);
         cyc();
      end

      // saturation: a continuous load-use hazard yields one stall every two cycles
      reset = 1;
      clr();
      cyc();
      reset = 0;
      idex_memread = 1; idex_regwrite = 1; idex_rd = 5; ifid_rs2 = 5;
      repeat (2 * 65536 + 8) cyc();
      chk("stall_count saturated", 32'(stall_count), 32'hFFFF);
      chk("flush_count idle", 32'(flush_count), 0);

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock shared with all pipeline registers.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports ifid_rs1 and ifid_rs2, input, 5 bits each: source registers of the instruction in IF/ID.
REQ-005 SHALL have ports idex_rs1 and idex_rs2, input, 5 bits each: source registers of the instruction in ID/EX.
REQ-006 SHALL have port idex_rd, input, 5 bits, and ports idex_memread and idex_regwrite, input, 1 bit each: destination and control of the ID/EX instruction.
REQ-007 SHALL have port exmem_rd, input, 5 bits, and port exmem_regwrite, input, 1 bit: EX/MEM destination and write enable.
REQ-008 SHALL have port memwb_rd, input, 5 bits, and port memwb_regwrite, input, 1 bit: MEM/WB destination and write enable.
REQ-009 SHALL have port branch_taken, input, 1 bit: EX/MEM branch flag AND Zero, meaning PCBranch_EXMEM is to be loaded.
REQ-010 SHALL have ports pc_write and ifid_write, output, 1 bit each: hold enables for PC and IF/ID (1 = update).
REQ-011 SHALL have port idex_bubble, output, 1 bit: zero the 40-bit IDEX control bundle on the next edge.
REQ-012 SHALL have ports ifid_flush, idex_flush and exmem_flush, output, 1 bit each: squash the corresponding stage register.
REQ-013 SHALL have ports forward_a and forward_b, output, 2 bits each: ALU operand source selects (00 = register file, 10 = EX/MEM ALUresult, 01 = MEM/WB write-back data).
REQ-014 SHALL have port state, output, 2 bits: 00 = RUN, 01 = STALL, 10 = FLUSH.
REQ-015 SHALL have ports stall_count and flush_count, output, 16 bits each: event counters.

Function
REQ-016 SHALL compute the load-use hazard combinationally: lu = idex_memread AND idex_regwrite AND (idex_rd != 0) AND (idex_rd == ifid_rs1 OR idex_rd == ifid_rs2).
REQ-017 In RUN with branch_taken=1, the block SHALL assert ifid_flush, idex_flush and exmem_flush in the same cycle, SHALL force pc_write=1 (the branch target loads), and SHALL go to FLUSH on the next edge.
REQ-018 In RUN with branch_taken=0 and lu=1, the block SHALL drive pc_write=0, ifid_write=0 and idex_bubble=1 in the same cycle, and SHALL go to STALL on the next edge.
REQ-019 In RUN with neither condition, the block SHALL drive pc_write=1, ifid_write=1, with all flush and bubble outputs at 0.
REQ-020 STALL SHALL last exactly 1 cycle with pc_write=1, ifid_write=1 and lu ignored, then return to RUN; branch_taken in STALL SHALL be handled as in REQ-017.
REQ-021 FLUSH SHALL last exactly 1 cycle with pc_write=1, ifid_write=1 and lu and branch_taken ignored (squashed bubbles), then return to RUN.
REQ-022 When branch_taken and lu occur together, branch_taken SHALL win and no stall SHALL be recorded.
REQ-023 forward_a SHALL be 10 if exmem_regwrite AND exmem_rd != 0 AND exmem_rd == idex_rs1.
REQ-024 Otherwise forward_a SHALL be 01 if memwb_regwrite AND memwb_rd != 0 AND memwb_rd == idex_rs1, and otherwise 00.
REQ-025 forward_b SHALL follow the same rules as REQ-023 and REQ-024 using idex_rs2.
REQ-026 Forwarding SHALL be combinational and independent of state.
REQ-027 stall_count SHALL increment by 1 on each edge leaving RUN to STALL.
REQ-028 flush_count SHALL increment by 1 on each edge entering FLUSH.
REQ-029 Both counters SHALL saturate at 16'hFFFF, with no wrap.

Reset
REQ-030 With reset=1 at an edge, state SHALL become RUN and both counters SHALL become 0.
REQ-031 While reset=1, outputs SHALL be pc_write=0, ifid_write=0, idex_bubble=1, all flushes 1 and forward_a/forward_b 00.
REQ-032 Reset asserted mid-STALL or mid-FLUSH SHALL abort that state with no counter update.
REQ-033 The first cycle after reset deasserts SHALL behave as RUN.

Verification
REQ-034 Bench SHALL cover: idex_memread=1, idex_regwrite=1, idex_rd=5, ifid_rs2=5 -> pc_write=0, ifid_write=0, idex_bubble=1 for 1 cycle, state 01 next cycle, stall_count=1, RUN after.
REQ-035 Bench SHALL cover: branch_taken=1 in RUN -> ifid_flush, idex_flush and exmem_flush =1 in the same cycle, state 10 for 1 cycle, flush_count=1.
REQ-036 Bench SHALL cover: exmem_rd=memwb_rd=3, both regwrite=1, idex_rs1=3 -> forward_a=10; with exmem_regwrite=0 -> forward_a=01; with idex_rs1=0 -> 00.
REQ-037 Bench SHALL cover: branch_taken=1 together with lu=1 -> flush asserted, idex_bubble=0, stall_count unchanged.
REQ-038 Bench SHALL cover: 65536 forced stall events -> stall_count holds 16'hFFFF.
REQ-039 Bench SHALL cover: reset asserted in STALL -> state 00 next edge, counters 0.
